// File: rtl/stack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stack_pkg                                                       |
// | Purpose  : Shared types and constants for the stack requester and the      |
// |            3-bit stack pointer FSM it drives.                              |
// |            - req_state_e  : requester FSM states                           |
// |            - stk_state_e  : stack FSM state encodings (bench model use)    |
// |            - STACK_TOS_W / STACK_MAX_DEPTH : pointer width and top depth   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package stack_pkg;

   localparam int STACK_TOS_W     = 3;
   localparam int STACK_MAX_DEPTH = 7;

   // Requester FSM states.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      CHECK  = 3'd2,
      RESP   = 3'd3,
      REJECT = 3'd4,
      HALT   = 3'd5
   } req_state_e;

   // Stack pointer FSM states, as seen from outside the stack.
   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      NORMAL = 2'd1,
      FULL   = 2'd2,
      ERROR  = 2'd3
   } stk_state_e;

endpackage
`default_nettype wire

// File: rtl/stack_requester_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stack_requester_if                                              |
// | Purpose  : Request/response handshake between the request-generating       |
// |            datapath (master) and the stack requester (slave).              |
// | Signals  : req_valid, req_push       master -> slave                       |
// |            req_ready                 slave  -> master                      |
// |            rsp_valid, rsp_err,       slave  -> master (one-cycle response) |
// |            rsp_tos[TOS_W]                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface stack_requester_if
   import stack_pkg::*;
#(
   parameter int TOS_W = STACK_TOS_W
) ();

   logic             req_valid;
   logic             req_push;
   logic             req_ready;
   logic             rsp_valid;
   logic             rsp_err;
   logic [TOS_W-1:0] rsp_tos;

   modport master (
      output req_valid,
      output req_push,
      input  req_ready,
      input  rsp_valid,
      input  rsp_err,
      input  rsp_tos
   );

   modport slave (
      input  req_valid,
      input  req_push,
      output req_ready,
      output rsp_valid,
      output rsp_err,
      output rsp_tos
   );

endinterface
`default_nettype wire

// File: rtl/stack_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stack_requester                                                 |
// | Purpose  : Command-side initiator for the 3-bit stack pointer FSM. Turns   |
// |            each accepted push/pop request into a single-cycle pushenbl or  |
// |            popenbl strobe, tracks a shadow depth, refuses overflow and     |
// |            underflow before they reach the stack, and checks the returned  |
// |            tos/stack_full. A mismatch latches stk_error and halts the      |
// |            requester until reset.                                          |
// | Ports    : clk         in   clock, rising edge                             |
// |            reset_n     in   asynchronous active-low reset                  |
// |            bus         slv  request/response handshake                     |
// |            depth       out  shadow depth                                   |
// |            pushenbl    out  registered push strobe to the stack            |
// |            popenbl     out  registered pop strobe to the stack             |
// |            tos         in   stack pointer returned by the stack            |
// |            stack_full  in   full flag returned by the stack                |
// |            stk_error   out  sticky mismatch flag                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module stack_requester
   import stack_pkg::*;
#(
   parameter int TOS_W     = STACK_TOS_W,
   parameter int MAX_DEPTH = STACK_MAX_DEPTH
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   stack_requester_if.slave      bus,
   output      logic [TOS_W-1:0] depth,
   output      logic             pushenbl,
   output      logic             popenbl,
   input  wire logic [TOS_W-1:0] tos,
   input  wire logic             stack_full,
   output      logic             stk_error
);

   localparam logic [TOS_W-1:0] C_MAX_DEPTH = TOS_W'(MAX_DEPTH);
   localparam logic [TOS_W-1:0] C_ONE       = TOS_W'(1);

   req_state_e       r_state;
   req_state_e       w_next;

   logic [TOS_W-1:0] r_depth;
   logic [TOS_W-1:0] r_exp;
   logic [TOS_W-1:0] r_rsp_tos;
   logic             r_rsp_err;
   logic             r_stk_error;
   logic             r_pushenbl;
   logic             r_popenbl;

   logic             w_ready;
   logic             w_rsp_valid;
   logic             w_accept;
   logic             w_illegal;
   logic             w_issue;
   logic             w_mismatch;

   // Range checks run on the current depth, before any +/-1, so the
   // unsigned depth arithmetic can never wrap.
   assign w_accept   = bus.req_valid & w_ready;
   assign w_illegal  = bus.req_push ? (r_depth == C_MAX_DEPTH) : (r_depth == '0);
   assign w_issue    = w_accept & ~w_illegal;
   assign w_mismatch = (tos != r_exp) | stack_full;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next state and state-decoded outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_next      = r_state;
      w_ready     = 1'b0;
      w_rsp_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = ~r_stk_error;
            if (w_accept) begin
               w_next = w_illegal ? REJECT : ISSUE;
            end
         end
         ISSUE: begin
            w_next = CHECK;
         end
         CHECK: begin
            w_next = RESP;
         end
         RESP: begin
            w_rsp_valid = 1'b1;
            w_next      = r_stk_error ? HALT : IDLE;
         end
         REJECT: begin
            w_rsp_valid = 1'b1;
            w_next      = IDLE;
         end
         HALT: begin
            w_next = HALT;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: strobes, shadow depth, expected pointer and response
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_depth     <= '0;
         r_exp       <= '0;
         r_rsp_tos   <= '0;
         r_rsp_err   <= 1'b0;
         r_stk_error <= 1'b0;
         r_pushenbl  <= 1'b0;
         r_popenbl   <= 1'b0;
      end else begin
         // Strobes are high only in the single ISSUE cycle that follows a
         // legal accept, and the two are mutually exclusive by construction.
         r_pushenbl <= w_issue &  bus.req_push;
         r_popenbl  <= w_issue & ~bus.req_push;

         if (w_issue) begin
            r_exp <= bus.req_push ? (r_depth + C_ONE) : (r_depth - C_ONE);
         end

         // Rejected requests are consumed here and answered next cycle.
         if (w_accept && w_illegal) begin
            r_rsp_err <= 1'b1;
            r_rsp_tos <= r_depth;
         end

         if (r_state == CHECK) begin
            r_rsp_tos <= tos;
            if (w_mismatch) begin
               r_stk_error <= 1'b1;
               r_rsp_err   <= 1'b1;
            end else begin
               r_depth   <= r_exp;
               r_rsp_err <= 1'b0;
            end
         end
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_tos   = r_rsp_tos;
   assign depth         = r_depth;
   assign pushenbl      = r_pushenbl;
   assign popenbl       = r_popenbl;
   assign stk_error     = r_stk_error;

endmodule
`default_nettype wire

// File: tb/tb_stack_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stack_requester                                              |
// | Purpose  : Self-checking bench for stack_requester with a behavioural      |
// |            model of the 3-bit stack pointer FSM and a response scoreboard. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_stack_requester;
   import stack_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] depth;
   logic       pushenbl;
   logic       popenbl;
   logic [2:0] tos_in;
   logic       stack_full;
   logic       stk_error;

   stack_requester_if #(.TOS_W(3)) bus ();

   stack_requester #(.TOS_W(3), .MAX_DEPTH(7)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .depth      (depth),
      .pushenbl   (pushenbl),
      .popenbl    (popenbl),
      .tos        (tos_in),
      .stack_full (stack_full),
      .stk_error  (stk_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int push_pulses = 0;
   int pop_pulses = 0;
   bit full_seen = 1'b0;
   logic [3:0] exp_q[$];   // {rsp_err, rsp_tos}

   // Override of the pointer seen by the DUT, used to inject a mismatch.
   logic       force_tos = 1'b0;
   logic [2:0] force_val = 3'd0;

   // ---------------- behavioural stack pointer FSM ----------------
   stk_state_e m_state;
   logic [2:0] m_tos;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_state <= EMPTY;
         m_tos   <= 3'd0;
      end else if (m_state == ERROR) begin
         m_state <= ERROR;
      end else if (pushenbl && popenbl) begin
         m_state <= ERROR;
      end else if (pushenbl) begin
         if (m_tos == 3'd7) begin
            m_state <= FULL;
         end else begin
            m_tos   <= m_tos + 3'd1;
            m_state <= NORMAL;
         end
      end else if (popenbl) begin
         if (m_tos == 3'd0) begin
            m_state <= ERROR;
         end else begin
            m_tos   <= m_tos - 3'd1;
            m_state <= (m_tos == 3'd1) ? EMPTY : NORMAL;
         end
      end
   end

   assign stack_full = (m_state == FULL);
   assign tos_in     = force_tos ? force_val : m_tos;

   always @(posedge clk) cyc++;

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [3:0] e;
      if (reset_n) begin
         checks++;
         if (pushenbl && popenbl) begin
            errors++;
            $display("FAIL strobe_exclusive: got push=%0b pop=%0b required not both", pushenbl, popenbl);
         end
         if (pushenbl) push_pulses++;
         if (popenbl) pop_pulses++;
         if (stack_full) full_seen = 1'b1;
         if (bus.rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got err=%0b tos=%0d required no response", bus.rsp_err, bus.rsp_tos);
            end else begin
               e = exp_q.pop_front();
               if ({bus.rsp_err, bus.rsp_tos} !== e) begin
                  errors++;
                  $display("FAIL rsp_payload: got err=%0b tos=%0d required err=%0b tos=%0d",
                           bus.rsp_err, bus.rsp_tos, e[3], e[2:0]);
               end
            end
         end
      end
   end

   // ---------------- helpers (stimulus only) ----------------
   task automatic apply_reset();
      reset_n       = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_push  = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got req_ready=%0b required 1 within 20 cycles", bus.req_ready);
      end
   endtask

   // Legal request: strobe in T+1, response in T+3, ready again in T+4.
   task automatic legal_op(input bit push, input logic [2:0] exp_tos);
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_push  = push;
      exp_q.push_back({1'b0, exp_tos});
      @(posedge clk);
      @(negedge clk);                      // T+1
      bus.req_valid = 1'b0;
      checks++;
      if ({pushenbl, popenbl} !== {push, ~push}) begin
         errors++;
         $display("FAIL op_strobe: got push=%0b pop=%0b required push=%0b pop=%0b", pushenbl, popenbl, push, ~push);
      end
      @(negedge clk);                      // T+2
      checks++;
      if ({pushenbl, popenbl} !== 2'b00) begin
         errors++;
         $display("FAIL op_strobe_len: got push=%0b pop=%0b required 0 0", pushenbl, popenbl);
      end
      @(negedge clk);                      // T+3
      checks++;
      if (bus.rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL op_rsp_latency: got rsp_valid=%0b required 1", bus.rsp_valid);
      end
      @(negedge clk);                      // T+4
      checks++;
      if (bus.req_ready !== 1'b1 || depth !== exp_tos) begin
         errors++;
         $display("FAIL op_done: got ready=%0b depth=%0d required ready=1 depth=%0d", bus.req_ready, depth, exp_tos);
      end
   endtask

   // Refused request: response in T+1, no strobe, ready in T+2.
   task automatic reject_op(input bit push, input logic [2:0] exp_tos);
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_push  = push;
      exp_q.push_back({1'b1, exp_tos});
      @(posedge clk);
      @(negedge clk);                      // T+1
      bus.req_valid = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b1 || {pushenbl, popenbl} !== 2'b00) begin
         errors++;
         $display("FAIL reject_t1: got rsp_valid=%0b push=%0b pop=%0b required 1 0 0", bus.rsp_valid, pushenbl, popenbl);
      end
      @(negedge clk);                      // T+2
      checks++;
      if (bus.req_ready !== 1'b1 || {pushenbl, popenbl} !== 2'b00 || depth !== exp_tos) begin
         errors++;
         $display("FAIL reject_t2: got ready=%0b push=%0b pop=%0b depth=%0d required 1 0 0 %0d",
                  bus.req_ready, pushenbl, popenbl, depth, exp_tos);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      checks++;
      if (depth !== 3'd0 || pushenbl !== 1'b0 || popenbl !== 1'b0) begin
         errors++;
         $display("FAIL reset_core: got depth=%0d push=%0b pop=%0b required 0 0 0", depth, pushenbl, popenbl);
      end
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_tos !== 3'd0) begin
         errors++;
         $display("FAIL reset_rsp: got valid=%0b err=%0b tos=%0d required 0 0 0", bus.rsp_valid, bus.rsp_err, bus.rsp_tos);
      end
      checks++;
      if (stk_error !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags: got stk_error=%0b ready=%0b required 0 1", stk_error, bus.req_ready);
      end
   endtask

   task automatic test_fill();
      int p0 = push_pulses;
      full_seen = 1'b0;
      for (int i = 1; i <= 7; i++) legal_op(1'b1, 3'(i));
      checks++;
      if (push_pulses - p0 != 7 || depth !== 3'd7 || full_seen !== 1'b0) begin
         errors++;
         $display("FAIL fill: got pulses=%0d depth=%0d full_seen=%0b required 7 7 0", push_pulses - p0, depth, full_seen);
      end
   endtask

   task automatic test_overflow();
      int p0 = push_pulses;
      reject_op(1'b1, 3'd7);
      checks++;
      if (push_pulses != p0 || depth !== 3'd7) begin
         errors++;
         $display("FAIL overflow: got extra_pulses=%0d depth=%0d required 0 7", push_pulses - p0, depth);
      end
   endtask

   task automatic test_underflow();
      int p0;
      apply_reset();
      p0 = pop_pulses;
      reject_op(1'b0, 3'd0);
      checks++;
      if (pop_pulses != p0) begin
         errors++;
         $display("FAIL underflow_strobe: got pop pulses=%0d required 0", pop_pulses - p0);
      end
      legal_op(1'b1, 3'd1);
   endtask

   task automatic test_back_to_back();
      int last = 0;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bit push = (i % 2) == 1;
         wait_ready();
         bus.req_push = push;
         exp_q.push_back({1'b0, 2'b00, push});
         @(posedge clk);
         @(negedge clk);                   // T+1
         checks++;
         if ({pushenbl, popenbl} !== {push, ~push}) begin
            errors++;
            $display("FAIL b2b_strobe: got push=%0b pop=%0b required push=%0b pop=%0b", pushenbl, popenbl, push, ~push);
         end
         if (i > 0) begin
            checks++;
            if (cyc - last != 4) begin
               errors++;
               $display("FAIL b2b_spacing: got %0d cycles required 4", cyc - last);
            end
         end
         last = cyc;
         repeat (3) @(negedge clk);        // T+4
         if (i == 5) bus.req_valid = 1'b0;
         checks++;
         if (depth !== {2'b00, push}) begin
            errors++;
            $display("FAIL b2b_depth: got %0d required %0d", depth, push);
         end
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic test_mismatch();
      int p0 = push_pulses;
      int q0 = pop_pulses;
      force_tos = 1'b1;
      force_val = 3'd5;
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_push  = 1'b1;
      exp_q.push_back({1'b1, 3'd5});
      @(posedge clk);
      @(negedge clk);                      // T+1
      repeat (2) @(negedge clk);           // T+3
      checks++;
      if (bus.rsp_valid !== 1'b1 || stk_error !== 1'b1) begin
         errors++;
         $display("FAIL mismatch_flag: got rsp_valid=%0b stk_error=%0b required 1 1", bus.rsp_valid, stk_error);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (bus.req_ready !== 1'b0 || {pushenbl, popenbl} !== 2'b00) begin
            errors++;
            $display("FAIL halt: got ready=%0b push=%0b pop=%0b required 0 0 0", bus.req_ready, pushenbl, popenbl);
         end
      end
      bus.req_valid = 1'b0;
      checks++;
      if (push_pulses - p0 != 1 || pop_pulses != q0 || depth !== 3'd1 || stk_error !== 1'b1) begin
         errors++;
         $display("FAIL mismatch_after: got pushes=%0d pops=%0d depth=%0d stk_error=%0b required 1 0 1 1",
                  push_pulses - p0, pop_pulses - q0, depth, stk_error);
      end
      force_tos = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      apply_reset();
      for (int i = 1; i <= 3; i++) legal_op(1'b1, 3'(i));
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_push  = 1'b1;
      @(posedge clk);
      @(negedge clk);                      // ISSUE
      bus.req_valid = 1'b0;
      checks++;
      if (pushenbl !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre: got pushenbl=%0b required 1", pushenbl);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (pushenbl !== 1'b0 || depth !== 3'd0) begin
         errors++;
         $display("FAIL midreset_drop: got pushenbl=%0b depth=%0d required 0 0", pushenbl, depth);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || depth !== 3'd0 || stk_error !== 1'b0) begin
         errors++;
         $display("FAIL midreset_after: got ready=%0b depth=%0d stk_error=%0b required 1 0 0", bus.req_ready, depth, stk_error);
      end
      legal_op(1'b1, 3'd1);
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_push  = 1'b0;
      test_reset();
      test_fill();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_mismatch();
      test_reset_mid_op();
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rsp_missing: got %0d outstanding responses required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000 time units required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/stack_requester.md
# stack_requester

Command-side initiator for the 3-bit stack pointer FSM. It accepts push/pop requests over a valid/ready interface and converts each into a single-cycle `pushenbl` or `popenbl` strobe, never both at once. It keeps a shadow depth count, rejects overflow and underflow before they reach the stack, and checks the returned `tos`/`stack_full` against the expected value. It sits between the request-generating datapath and the stack FSM, so the stack never enters its FULL or ERROR states.

## Interface
- `TOS_W`, default 3: width of `tos` and of the depth count.
- `MAX_DEPTH`, default 7: highest legal depth, equal to 2**TOS_W-1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_push`  in  1: 1 = push, 0 = pop. Qualified by `req_valid`.
- `req_ready`  out  1: request accepted when `req_valid & req_ready`.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_err`  out  1: valid with `rsp_valid`. Set on rejected or mismatched operation.
- `rsp_tos`  out  TOS_W: depth after the operation. Valid with `rsp_valid`.
- `depth`  out  TOS_W: current shadow depth.
- `pushenbl`  out  1: push strobe to the stack FSM.
- `popenbl`  out  1: pop strobe to the stack FSM.
- `tos`  in  TOS_W: stack pointer returned by the stack FSM.
- `stack_full`  in  1: full flag returned by the stack FSM.
- `stk_error`  out  1: sticky mismatch flag. Cleared only by reset.

## Operation
- States:
  - IDLE: accepts a request.
  - ISSUE: drives the strobe.
  - CHECK: compares `tos`/`stack_full` against `exp`.
  - RESP: drives the response.
  - REJECT: refuses the request.
  - HALT: dead until reset.
- IDLE, accepted push with `depth == MAX_DEPTH` → REJECT. Accepted pop with `depth == 0` → REJECT. Otherwise → ISSUE, and register `exp` = `depth` ± 1.
- ISSUE: exactly one of `pushenbl`/`popenbl` is high for this one cycle, then → CHECK.
- CHECK: mismatch is `tos != exp` or `stack_full == 1`.
  - Match: `depth` ← `exp`, `rsp_err` ← 0.
  - Mismatch: `stk_error` ← 1, `rsp_err` ← 1, `depth` unchanged.
  - Either way → RESP.
- RESP: `rsp_valid` = 1 and `rsp_tos` = `tos` sampled in CHECK. Then → HALT if `stk_error`, else → IDLE.
- REJECT: `rsp_valid` = 1, `rsp_err` = 1, `rsp_tos` = `depth`. No strobe is issued and `depth` is unchanged. Then → IDLE.
- HALT: terminal until reset. `req_ready` = 0 and no strobes are issued.
- `req_ready` = (state == IDLE) & ~`stk_error`.
- Rejected requests are consumed. The requester must not hold a rejected request for a retry.
- Depth arithmetic is unsigned TOS_W-bit. Range checks happen before the ±1, so wrap can never occur.
- `pushenbl`/`popenbl` are registered outputs. The stack FSM's `pushenbl & popenbl` error case is unreachable.

## Timing
- Reset values (all outputs registered or decoded from state):
  - state = IDLE, `depth` = 0, `exp` = 0.
  - `pushenbl` = `popenbl` = 0.
  - `rsp_valid` = 0, `rsp_err` = 0, `rsp_tos` = 0.
  - `stk_error` = 0, `req_ready` = 1.
- Accepted legal request at cycle T:
  - strobe high in T+1;
  - stack updates `tos` at end of T+1;
  - compare in T+2;
  - `rsp_valid` in T+3;
  - `req_ready` high again in T+4.
  - Throughput is 1 operation per 4 cycles.
- Rejected request at T: `rsp_valid`/`rsp_err` in T+1, `req_ready` in T+2.
- `reset_n` low mid-operation: all state clears immediately and any strobe drops in the same cycle. The stack FSM must be reset by the same event; at top level, stack `reset` = ~`reset_n`.
- `req_push` and `req_valid` are ignored outside IDLE.

## Structure
- Shared package `stack_pkg` holds:
  - the state enum (IDLE, ISSUE, CHECK, RESP, REJECT, HALT);
  - `STACK_TOS_W` = 3 and `STACK_MAX_DEPTH` = 7;
  - the stack FSM's state encodings (EMPTY, NORMAL, FULL, ERROR), for bench use.
- Single module, no sub-module. A test-only behavioural model of the stack FSM is instantiated in the bench, not in the RTL.

## Test plan
- Reset, then 7 pushes → each `rsp_err` = 0, `rsp_tos` = 1..7, one `pushenbl` pulse per operation, `depth` = 7, `stack_full` never 1.
- Depth 7, push → REJECT in T+1, `rsp_err` = 1, `rsp_tos` = 7, no `pushenbl`, `depth` stays 7.
- Depth 0, pop → `rsp_err` = 1, `rsp_tos` = 0, no `popenbl`. Then a push → `rsp_tos` = 1.
- Alternating push/pop with `req_valid` held high → strobes 4 cycles apart, never both high, `depth` toggles 1/0.
- Bench forces `tos` = 5 while `exp` = 2 → `rsp_err` = 1, `stk_error` = 1, `req_ready` stays 0 afterwards, no further strobes.
- `reset_n` asserted during ISSUE at depth 3 → `pushenbl` drops immediately. After release: `depth` = 0, `req_ready` = 1, next push returns `rsp_tos` = 1.
